grf_hazard_scoreboard: RTL and testbench

- Scheduling controller for the 32x32 general register file in the five-stage pipeline (F/D/E/M/W).
- Tracks in-flight register writes in a 3-slot scoreboard covering E, M and W, each slot with a countdown of cycles until its result exists.
- Decides each cycle whether the D-stage instruction stalls, and which stage drives each D-stage operand.
- W-stage results reach D through the GRF's write-through bypass, so this block only selects E, M or the GRF port.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/sb_operand_check.sv | 38 +++
 rtl/grf_hazard_scoreboard.sv | 93 +++++++++
 tb/tb_grf_hazard_scoreboard.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: Tnew/Tuse encodings, forward-select codes and
// the hazard scoreboard slot record.
package cpu_pkg;

  localparam int SB_AW = 5;
  localparam int SB_TW = 2;

  localparam logic [SB_TW-1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  localparam logic [SB_TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [SB_TW-1:0] TNEW_LOAD = 2'd2;
  localparam logic [SB_TW-1:0] TNEW_LINK = 2'd0;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] wa;
    logic [SB_TW-1:0] tnew;
  } slot_t;

  // Advance a slot by one stage; an empty slot stays fully zeroed so the
  // exported addresses read 0.
  function automatic slot_t slot_age(input slot_t s);
    slot_t r;
    r = '0;
    if (s.valid) begin
      r.valid = 1'b1;
      r.wa    = s.wa;
      r.tnew  = (s.tnew == '0) ? '0 : s.tnew - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_operand_check.sv
// Per-operand hazard evaluation: stall term and forward select for one
// D-stage source register against the E/M/W scoreboard slots.
module sb_operand_check
  import cpu_pkg::*;
(
  input  slot_t            e_slot_i,
  input  slot_t            m_slot_i,
  input  slot_t            w_slot_i,
  input  logic [SB_AW-1:0] r_i,
  input  logic [SB_TW-1:0] tuse_i,
  output logic             stall_o,
  output logic [1:0]       fwd_sel_o
);

  logic e_hit;
  logic m_hit;
  logic w_hit;

  always_comb begin
    e_hit = e_slot_i.valid && (e_slot_i.wa == r_i) && (r_i != '0);
    m_hit = m_slot_i.valid && (m_slot_i.wa == r_i) && (r_i != '0);
    w_hit = w_slot_i.valid && (w_slot_i.wa == r_i) && (r_i != '0);

    stall_o = (e_hit && (e_slot_i.tnew > tuse_i)) ||
              (m_hit && (m_slot_i.tnew > tuse_i)) ||
              (w_hit && (w_slot_i.tnew > tuse_i));

    // The youngest match decides; a not-yet-ready youngest value must not
    // fall back to an older stage, so it yields the GRF port.
    fwd_sel_o = FWD_GRF;
    if (e_hit) begin
      if (e_slot_i.tnew == '0) fwd_sel_o = FWD_E;
    end else if (m_hit) begin
      if (m_slot_i.tnew == '0) fwd_sel_o = FWD_M;
    end
  end

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// Register-write hazard scoreboard for the five-stage pipeline: tracks E/M/W
// writes, raises the D-stage stall and picks the operand forwarding source.
module grf_hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int TW = SB_TW,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_wa,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_is_md,
  input  logic          md_busy,
  input  logic          md_start,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel,
  output logic [AW-1:0] e_wa,
  output logic [AW-1:0] m_wa,
  output logic [AW-1:0] w_wa,
  output logic [CW-1:0] stall_cnt
);

  slot_t         e_q, m_q, w_q;
  slot_t         e_d, m_d, w_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          rs_stall, rt_stall;

  sb_operand_check u_rs_check (
    .e_slot_i  (e_q),
    .m_slot_i  (m_q),
    .w_slot_i  (w_q),
    .r_i       (d_rs),
    .tuse_i    (d_tuse_rs),
    .stall_o   (rs_stall),
    .fwd_sel_o (fwd_rs_sel)
  );

  sb_operand_check u_rt_check (
    .e_slot_i  (e_q),
    .m_slot_i  (m_q),
    .w_slot_i  (w_q),
    .r_i       (d_rt),
    .tuse_i    (d_tuse_rt),
    .stall_o   (rt_stall),
    .fwd_sel_o (fwd_rt_sel)
  );

  always_comb begin
    stall = d_valid && !flush &&
            (rs_stall || rt_stall || (d_is_md && (md_busy || md_start)));

    // Slots never freeze: a stalled or flushed D instruction becomes a bubble.
    e_d = '0;
    m_d = flush ? '0 : slot_age(e_q);
    w_d = slot_age(m_q);
    if (d_valid && !stall && !flush && (d_wa != '0)) begin
      e_d.valid = 1'b1;
      e_d.wa    = d_wa;
      e_d.tnew  = d_tnew;
    end

    stall_cnt_d = stall ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign e_wa      = e_q.valid ? e_q.wa : '0;
  assign m_wa      = m_q.valid ? m_q.wa : '0;
  assign w_wa      = w_q.valid ? w_q.wa : '0;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Directed bench for grf_hazard_scoreboard: each step drives one D-stage
// instruction, queues the expected outputs and compares them mid-cycle.
module tb_grf_hazard_scoreboard;

  localparam int EW = 1 + 2 + 2 + 5 + 5 + 5 + 32;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_is_md, md_busy, md_start, flush;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [4:0]  e_wa, m_wa, w_wa;
  logic [31:0] stall_cnt;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_cnt;
  int            checks;
  int            failures;
  int            step_no;

  grf_hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wa       (d_wa),
    .d_tnew     (d_tnew),
    .d_is_md    (d_is_md),
    .md_busy    (md_busy),
    .md_start   (md_start),
    .flush      (flush),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .e_wa       (e_wa),
    .m_wa       (m_wa),
    .w_wa       (w_wa),
    .stall_cnt  (stall_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: one pipeline cycle with the expected outputs for that cycle
  task automatic step(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] rt, input logic [1:0] trt,
                      input logic [4:0] wa, input logic [1:0] tn,
                      input logic md, input logic busy, input logic start,
                      input logic fl, input logic rst,
                      input logic es, input logic [1:0] ers, input logic [1:0] ert,
                      input logic [4:0] ee, input logic [4:0] em, input logic [4:0] ew);
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    d_valid   = v;
    d_rs      = rs;
    d_tuse_rs = trs;
    d_rt      = rt;
    d_tuse_rt = trt;
    d_wa      = wa;
    d_tnew    = tn;
    d_is_md   = md;
    md_busy   = busy;
    md_start  = start;
    flush     = fl;
    reset     = rst;
    exp_q.push_back({es, ers, ert, ee, em, ew, exp_cnt});
    @(negedge clk);
    step_no++;
    got = {stall, fwd_rs_sel, fwd_rt_sel, e_wa, m_wa, w_wa, stall_cnt};
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL step%0d stall/rs/rt/e/m/w/cnt got=%0b/%0d/%0d/%0d/%0d/%0d/%0d exp=%0b/%0d/%0d/%0d/%0d/%0d/%0d",
             step_no, got[51], got[50:49], got[48:47], got[46:42], got[41:37], got[36:32], got[31:0],
             exp[51], exp[50:49], exp[48:47], exp[46:42], exp[41:37], exp[36:32], exp[31:0]);
    end
    if (rst) exp_cnt = '0;
    else if (es) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; step_no = 0; exp_cnt = '0;
    d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_wa = 0; d_tnew = 0;
    d_is_md = 0; md_busy = 0; md_start = 0; flush = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    //   v  rs trs rt trt wa tn md by st fl rst | stall rs rt  e  m  w
    step(0, 0, 3, 0, 3,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);  // reset state
    // load-use
    step(1, 0, 3, 0, 3,  8, 2, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    step(1, 8, 0, 9, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  8, 0, 0);
    step(1, 8, 0, 9, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  0, 8, 0);
    step(1, 8, 0, 9, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 8);
    // ALU chain, M forward on rs then rt
    step(1, 1, 1, 2, 1,  9, 1, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    step(1, 9, 1, 3, 1, 10, 1, 0, 0, 0, 0, 0,   0, 0, 0,  9, 0, 0);
    step(1, 9, 0,10, 1,  0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 10, 9, 0);
    step(1,10, 0, 9, 0,  0, 0, 0, 0, 0, 0, 0,   0, 2, 0,  0,10, 9);
    // link forward, rs==rt both read
    step(1, 0, 3, 0, 3, 31, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0,10);
    step(1,31, 0,31, 0,  0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 31, 0, 0);
    // E beats M for the same register
    step(1, 0, 3, 0, 3,  5, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0,31, 0);
    step(1, 0, 3, 0, 3,  5, 1, 0, 0, 0, 0, 0,   0, 0, 0,  5, 0,31);
    step(1, 5, 1, 5, 0,  0, 0, 0, 0, 0, 0, 0,   1, 0, 0,  5, 5, 0);
    step(1, 5, 1, 5, 0,  0, 0, 0, 0, 0, 0, 0,   0, 2, 2,  0, 5, 5);
    // zero register
    step(1, 0, 3, 0, 3,  0, 2, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 5);
    step(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    // MDU
    step(1, 0, 3, 0, 3,  0, 0, 1, 1, 0, 0, 0,   1, 0, 0,  0, 0, 0);
    step(1, 0, 3, 0, 3,  0, 0, 1, 1, 0, 0, 0,   1, 0, 0,  0, 0, 0);
    step(1, 0, 3, 0, 3,  0, 0, 1, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    step(1, 0, 3, 0, 3,  0, 0, 0, 1, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    step(1, 0, 3, 0, 3,  0, 0, 1, 0, 1, 0, 0,   1, 0, 0,  0, 0, 0);
    step(0, 0, 3, 0, 3,  0, 0, 1, 1, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    // flush during a load-use stall; discarded D writer must not enter E
    step(1, 0, 3, 0, 3,  8, 2, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    step(1, 0, 3, 0, 3,  7, 1, 0, 0, 0, 0, 0,   0, 0, 0,  8, 0, 0);
    step(1, 7, 0, 8, 0, 12, 1, 0, 0, 0, 1, 0,   0, 0, 0,  7, 8, 0);
    step(0, 0, 3, 0, 3,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 8);
    // reset mid-stream
    step(1, 0, 3, 0, 3,  4, 2, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    step(1, 4, 0, 0, 3,  6, 1, 0, 0, 0, 0, 0,   1, 0, 0,  4, 0, 0);
    step(0, 4, 0, 0, 3,  6, 1, 0, 0, 0, 1, 1,   0, 0, 0,  0, 4, 0);
    step(1, 4, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
